// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - instr/data port arbiter onto one Avalon-MM master; optional watchdog via ARB_TIMEOUT_EN
module avalon_mem_arbiter #(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_ack,
    output logic [31:0] instr_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_byteenable,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, INSTR_RD, DATA_RD, DATA_WR} state_t;

    localparam bit DATA_FIRST = (DATA_PRIORITY != 0);

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        instr_ack_q, instr_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    // 1 = data wins the next contested arbitration (alternating mode only)
    logic        alt_data_q, alt_data_d;

    logic        instr_elig, data_elig, pick_data, finish;
    logic [31:0] rd_val;
    logic        unused_addr_lsb;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        bus_error_q, bus_error_d;
`else
    logic        unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // byte-offset bits are dropped on the word-aligned bus
    assign unused_addr_lsb = ^{instr_addr[1:0], data_addr[1:0]};

    // an acked port is masked so its still-held request is not re-issued
    assign instr_elig = instr_req && !instr_ack_q;
    assign data_elig  = data_req  && !data_ack_q;
    assign pick_data  = data_elig && (!instr_elig || DATA_FIRST || alt_data_q);

    // next-state: grant in IDLE, wait out waitrequest in the bus states
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        instr_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        alt_data_d    = alt_data_q;
        finish        = 1'b0;
        rd_val        = readdata;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        bus_error_d   = bus_error_q;
`endif
        case (state_q)
            IDLE: begin
                if (instr_elig && data_elig) begin
                    alt_data_d = !pick_data;
                end
                if (pick_data) begin
                    address_d    = {data_addr[31:2], 2'b00};
                    byteenable_d = data_byteenable;
                    writedata_d  = data_wdata;
                    state_d      = data_we ? DATA_WR : DATA_RD;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = 16'd0;
`endif
                end else if (instr_elig) begin
                    address_d    = {instr_addr[31:2], 2'b00};
                    byteenable_d = 4'b1111;
                    state_d      = INSTR_RD;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = 16'd0;
`endif
                end
            end
            default: begin
                if (!waitrequest) begin
                    finish = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q + 16'd1 >= TIMEOUT_W) begin
                    finish      = 1'b1;
                    rd_val      = 32'hDEADBEEF;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
                if (finish) begin
                    state_d = IDLE;
                    case (state_q)
                        INSTR_RD: begin
                            instr_ack_d   = 1'b1;
                            instr_rdata_d = rd_val;
                        end
                        DATA_RD: begin
                            data_ack_d   = 1'b1;
                            data_rdata_d = rd_val;
                        end
                        default: data_ack_d = 1'b1;
                    endcase
                end
            end
        endcase
    end

    // state and transaction registers; reset aborts any bus cycle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            address_q     <= 32'd0;
            writedata_q   <= 32'd0;
            byteenable_q  <= 4'd0;
            instr_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            instr_rdata_q <= 32'd0;
            data_rdata_q  <= 32'd0;
            alt_data_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= 16'd0;
            bus_error_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            instr_ack_q   <= instr_ack_d;
            data_ack_q    <= data_ack_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            alt_data_q    <= alt_data_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            bus_error_q   <= bus_error_d;
`endif
        end
    end

    assign address     = address_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign read        = (state_q == INSTR_RD) || (state_q == DATA_RD);
    assign write       = (state_q == DATA_WR);
    assign busy        = (state_q != IDLE);
    assign instr_ack   = instr_ack_q;
    assign data_ack    = data_ack_q;
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_error   = bus_error_q;
`else
    assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb/tb_avalon_mem_arbiter.sv - directed scoreboard bench for avalon_mem_arbiter
module tb_avalon_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic        data_we, waitrequest;
    logic [3:0]  data_byteenable;

    logic        instr_req_a, data_req_a, instr_ack_a, data_ack_a;
    logic [31:0] instr_rdata_a, data_rdata_a, address_a, writedata_a, readdata_a;
    logic        read_a, write_a, busy_a, bus_error_a;
    logic [3:0]  byteenable_a;

    logic        instr_req_b, data_req_b, instr_ack_b, data_ack_b;
    logic [31:0] instr_rdata_b, data_rdata_b, address_b, writedata_b, readdata_b;
    logic        read_b, write_b, busy_b, bus_error_b;
    logic [3:0]  byteenable_b;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        sb_q[$];
    int          rd_cnt = 0;
    logic [31:0] rd_addr_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_1004) ? 32'h2402_0005 : ((a ^ 32'hA5A5_0000) + 32'h11);
    endfunction

    assign readdata_a = mem_word(address_a);
    assign readdata_b = mem_word(address_b);

    avalon_mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .instr_req(instr_req_a), .instr_addr(instr_addr),
        .instr_ack(instr_ack_a), .instr_rdata(instr_rdata_a),
        .data_req(data_req_a), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_ack(data_ack_a), .data_rdata(data_rdata_a),
        .address(address_a), .read(read_a), .write(write_a),
        .writedata(writedata_a), .byteenable(byteenable_a),
        .waitrequest(waitrequest), .readdata(readdata_a),
        .busy(busy_a), .bus_error(bus_error_a)
    );

    avalon_mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .instr_req(instr_req_b), .instr_addr(instr_addr),
        .instr_ack(instr_ack_b), .instr_rdata(instr_rdata_b),
        .data_req(data_req_b), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_byteenable(data_byteenable),
        .data_ack(data_ack_b), .data_rdata(data_rdata_b),
        .address(address_b), .read(read_b), .write(write_b),
        .writedata(writedata_b), .byteenable(byteenable_b),
        .waitrequest(waitrequest), .readdata(readdata_b),
        .busy(busy_b), .bus_error(bus_error_b)
    );

    // completed bus reads on instance a, seen mid-cycle before the completing edge
    always @(negedge clk) begin
        if (!reset && read_a && !waitrequest) begin
            rd_cnt = rd_cnt + 1;
            rd_addr_q.push_back(address_a);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic take_ack(input bit use_b, input bit drop);
        logic        ia, da;
        logic [31:0] ir, dr;
        exp_t        e;
        ia = use_b ? instr_ack_b : instr_ack_a;
        da = use_b ? data_ack_b : data_ack_a;
        ir = use_b ? instr_rdata_b : instr_rdata_a;
        dr = use_b ? data_rdata_b : data_rdata_a;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_empty observed=ack expected=no_ack");
        end else begin
            e = sb_q.pop_front();
            chk("ack_port", {31'd0, da}, {31'd0, e.port});
            if (e.chk_rd) chk("ack_rdata", da ? dr : ir, e.rdata);
        end
        if (drop) begin
            if (ia) begin
                if (use_b) instr_req_b = 1'b0; else instr_req_a = 1'b0;
            end
            if (da) begin
                if (use_b) data_req_b = 1'b0; else data_req_a = 1'b0;
            end
        end
    endtask

    task automatic wait_ack(input bit use_b, input bit drop);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (use_b ? (instr_ack_b || data_ack_b) : (instr_ack_a || data_ack_a)) begin
                take_ack(use_b, drop);
                got = 1'b1;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $error("FAIL ack_timeout observed=none expected=ack");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        instr_req_a = 0; data_req_a = 0; instr_req_b = 0; data_req_b = 0;
        instr_addr = 0; data_addr = 0; data_wdata = 0; data_we = 0;
        data_byteenable = 0; waitrequest = 0;
        step(); step();
        chk("rst_address", address_a, 32'd0);
        chk("rst_strobes", {28'd0, read_a, write_a, busy_a, bus_error_a}, 32'd0);
        chk("rst_acks", {30'd0, instr_ack_a, data_ack_a}, 32'd0);
        chk("rst_rdata", instr_rdata_a | data_rdata_a | writedata_a, 32'd0);
        chk("rst_be", {28'd0, byteenable_a}, 32'd0);
        reset = 1'b0;
        step();

        // single fetch, no wait states
        instr_addr = 32'h0000_1006;
        instr_req_a = 1'b1;
        sb_q.push_back('{1'b0, 32'h2402_0005, 1'b1});
        step();
        chk("f_address", address_a, 32'h0000_1004);
        chk("f_rd_be", {26'd0, read_a, write_a, byteenable_a}, {26'd0, 1'b1, 1'b0, 4'hF});
        chk("f_early_ack", {31'd0, instr_ack_a}, 32'd0);
        step();
        chk("f_ack", {29'd0, instr_ack_a, read_a, busy_a}, {29'd0, 1'b1, 1'b0, 1'b0});
        take_ack(1'b0, 1'b1);
        step();
        chk("f_ack_pulse", {31'd0, instr_ack_a}, 32'd0);
        chk("f_rdata_hold", instr_rdata_a, 32'h2402_0005);

        // store with three wait states, zero-based on bus fields
        data_addr = 32'h20; data_wdata = 32'hCAFE_F00D; data_byteenable = 4'b0011;
        data_we = 1'b1; waitrequest = 1'b1; data_req_a = 1'b1;
        sb_q.push_back('{1'b1, 32'd0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s_rw", {30'd0, read_a, write_a}, 32'd1);
            chk("s_fields", address_a ^ writedata_a ^ {28'd0, byteenable_a},
                32'h20 ^ 32'hCAFE_F00D ^ 32'd3);
            chk("s_no_ack", {31'd0, data_ack_a}, 32'd0);
            if (k == 3) waitrequest = 1'b0;
        end
        step();
        chk("s_ack", {29'd0, data_ack_a, write_a, read_a}, {29'd0, 1'b1, 1'b0, 1'b0});
        take_ack(1'b0, 1'b1);
        data_we = 1'b0;
        step();

        // simultaneous requests, data priority
        instr_addr = 32'h100; data_addr = 32'h200;
        sb_q.push_back('{1'b1, mem_word(32'h200), 1'b1});
        sb_q.push_back('{1'b0, mem_word(32'h100), 1'b1});
        instr_req_a = 1'b1; data_req_a = 1'b1;
        wait_ack(1'b0, 1'b1);
        step();
        chk("p_instr_next", {read_a, address_a[30:0]}, {1'b1, 31'h100});
        wait_ack(1'b0, 1'b1);
        step();

        // alternating priority: instr then data, then data then instr
        sb_q.push_back('{1'b0, mem_word(32'h100), 1'b1});
        sb_q.push_back('{1'b1, mem_word(32'h200), 1'b1});
        instr_req_b = 1'b1; data_req_b = 1'b1;
        wait_ack(1'b1, 1'b1);
        wait_ack(1'b1, 1'b1);
        step();
        sb_q.push_back('{1'b1, mem_word(32'h200), 1'b1});
        sb_q.push_back('{1'b0, mem_word(32'h100), 1'b1});
        instr_req_b = 1'b1; data_req_b = 1'b1;
        wait_ack(1'b1, 1'b1);
        wait_ack(1'b1, 1'b1);
        step();

        // held request with address changed in ack cycle -> no duplicate read
        rd_cnt = 0;
        rd_addr_q.delete();
        instr_addr = 32'h300;
        sb_q.push_back('{1'b0, mem_word(32'h300), 1'b1});
        sb_q.push_back('{1'b0, mem_word(32'h304), 1'b1});
        instr_req_a = 1'b1;
        wait_ack(1'b0, 1'b0);
        instr_addr = 32'h304;
        wait_ack(1'b0, 1'b1);
        step(); step(); step();
        chk("d_read_count", rd_cnt, 32'd2);
        if (rd_addr_q.size() >= 2) begin
            chk("d_addr0", rd_addr_q[0], 32'h300);
            chk("d_addr1", rd_addr_q[1], 32'h304);
        end

        // reset during a stalled read
        waitrequest = 1'b1;
        instr_addr = 32'h400;
        instr_req_a = 1'b1;
        step(); step();
        chk("r_read_before", {31'd0, read_a}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("r_async_drop", {30'd0, read_a, busy_a}, 32'd0);
        instr_req_a = 1'b0;
        step();
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("r_no_ack", {30'd0, instr_ack_a, read_a}, 32'd0);
        end
        instr_addr = 32'h500;
        sb_q.push_back('{1'b0, mem_word(32'h500), 1'b1});
        instr_req_a = 1'b1;
        wait_ack(1'b0, 1'b1);
        step();

`ifdef ARB_TIMEOUT_EN
        begin
            int rc;
            bit got;
            rc = 0;
            got = 1'b0;
            waitrequest = 1'b1;
            instr_addr = 32'h600;
            sb_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
            instr_req_a = 1'b1;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                if (read_a) rc++;
                if (instr_ack_a) begin
                    take_ack(1'b0, 1'b1);
                    got = 1'b1;
                end
            end
            chk("t_got_ack", {31'd0, got}, 32'd1);
            chk("t_read_cycles", rc, 32'd4);
            chk("t_bus_error", {31'd0, bus_error_a}, 32'd1);
            waitrequest = 1'b0;
            step(); step(); step();
            chk("t_bus_error_sticky", {31'd0, bus_error_a}, 32'd1);
        end
`else
        chk("no_timeout_error", {30'd0, bus_error_a, bus_error_b}, 32'd0);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
